// File: rtl/alu_bitop_seq.sv
// alu_bitop_seq: micro-sequencer for the CB-prefix BIT/RES/SET instructions.
// Takes one request (op, bit index, operand byte) and drives the
// nibble-serial ALU over three cycles: bit-select load, low nibble, high
// nibble. It then hands the result byte and F-flag updates back to the core.
// While busy it is the only driver of the ALU control lines.
module alu_bitop_seq #(
    parameter bit CHECK_CARRY = 1'b1
) (
    input  logic       clk,
    input  logic       nreset,

    // request side (instruction decoder)
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [2:0] req_bit,
    input  logic [7:0] req_val,

    // ALU control side
    output logic [2:0] alu_bs,
    output logic [7:0] alu_op,
    output logic [1:0] alu_oe,
    output logic       alu_la,
    output logic       alu_lb,
    output logic [1:0] alu_sh,
    output logic       alu_r,
    output logic       alu_s,
    output logic       alu_v,
    output logic       alu_ne,
    output logic       alu_ci,
    output logic       alu_l,
    output logic       alu_h,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    input  logic       alu_carry,

    // result side (CPU core)
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic       res_wr,
    output logic       res_z,
    output logic       res_n,
    output logic       res_h,
    output logic       err
);

    // sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LDB  = 2'd1;
    localparam logic [1:0] ST_LO   = 2'd2;
    localparam logic [1:0] ST_HI   = 2'd3;

    // request opcodes
    localparam logic [1:0] OP_BIT = 2'd0;
    localparam logic [1:0] OP_RES = 2'd1;
    localparam logic [1:0] OP_SET = 2'd2;

    // shared ALU control constants
    localparam logic [1:0] OE_NONE   = 2'd0;
    localparam logic [1:0] OE_BS     = 2'd1;
    localparam logic [1:0] OE_SH     = 2'd2;
    localparam logic [1:0] OE_RES    = 2'd3;
    localparam logic       NO_LD     = 1'b0;
    localparam logic       BUS_LD    = 1'b1;
    localparam logic [1:0] NO_SH     = 2'd0;

    logic [1:0] state_q, state_d;
    logic [1:0] op_q;
    logic [2:0] bit_q;
    logic [7:0] val_q;
    logic       accept;
    logic       is_bit;
    logic       carry_window;

    assign accept       = req_valid && req_ready;
    assign is_bit       = (op_q == OP_BIT);
    assign carry_window = (state_q == ST_LO) || (state_q == ST_HI);

    // ready only when no operation is mid-flight, or on its final cycle
    always_comb begin
        req_ready = 1'b0;
        if (state_q == ST_IDLE || state_q == ST_HI) begin
            req_ready = 1'b1;
        end
    end

    // next-state: fixed LDB->LO->HI walk, HI chains straight into a new op
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_LDB;
                end
            end
            ST_LDB:  state_d = ST_LO;
            ST_LO:   state_d = ST_HI;
            ST_HI: begin
                if (accept) begin
                    state_d = ST_LDB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // request capture; the reserved opcode is folded onto BIT here
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            op_q  <= OP_BIT;
            bit_q <= 3'd0;
            val_q <= 8'd0;
        end else if (accept) begin
            op_q  <= (req_op == 2'd3) ? OP_BIT : req_op;
            bit_q <= req_bit;
            val_q <= req_val;
        end
    end

    // ALU control drive, purely from state and the captured request
    always_comb begin
        alu_bs = 3'd0;
        alu_op = 8'd0;
        alu_oe = OE_NONE;
        alu_la = NO_LD;
        alu_lb = NO_LD;
        alu_sh = NO_SH;
        alu_r  = 1'b0;
        alu_s  = 1'b0;
        alu_v  = 1'b0;
        alu_ne = 1'b0;
        alu_ci = 1'b0;
        alu_l  = 1'b0;
        alu_h  = 1'b0;
        case (state_q)
            ST_LDB: begin
                // decoded bit mask goes to B
                alu_bs = bit_q;
                alu_oe = OE_BS;
                alu_lb = BUS_LD;
            end
            ST_LO: begin
                // operand goes to A through the (idle) shifter
                alu_op = val_q;
                alu_oe = OE_SH;
                alu_la = BUS_LD;
                alu_l  = 1'b1;
            end
            ST_HI: begin
                alu_oe = OE_RES;
                alu_h  = 1'b1;
            end
            default: begin
            end
        endcase
        if (carry_window) begin
            // SET: A|mask, RES: A&~mask, BIT: A&mask
            alu_s  = 1'b1;
            alu_v  = 1'b1;
            alu_r  = (op_q == OP_SET);
            alu_ne = (op_q == OP_RES);
        end
    end

    // result capture at the edge that ends HI; res_valid pulses one cycle
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            res_valid <= 1'b0;
            res_data  <= 8'd0;
            res_wr    <= 1'b0;
            res_z     <= 1'b0;
            res_n     <= 1'b0;
            res_h     <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (state_q == ST_HI) begin
                res_valid <= 1'b1;
                res_data  <= alu_result;
                res_z     <= alu_zero;
                res_n     <= 1'b0;
                res_h     <= is_bit;
                res_wr    <= !is_bit;
            end
        end
    end

    // sticky carry-violation flag, cleared only by reset
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            err <= 1'b0;
        end else if (CHECK_CARRY && carry_window && alu_carry) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_bitop_seq.sv
// Self-checking bench for alu_bitop_seq with a small behavioural ALU.
module tb_alu_bitop_seq;

    logic       clk;
    logic       nreset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [2:0] req_bit;
    logic [7:0] req_val;
    logic [2:0] alu_bs;
    logic [7:0] alu_op;
    logic [1:0] alu_oe;
    logic       alu_la, alu_lb;
    logic [1:0] alu_sh;
    logic       alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_carry;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_wr, res_z, res_n, res_h, err;

    int tests;
    int fails;
    bit err_exp;

    alu_bitop_seq #(.CHECK_CARRY(1'b1)) dut (
        .clk(clk), .nreset(nreset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_bit(req_bit), .req_val(req_val),
        .alu_bs(alu_bs), .alu_op(alu_op), .alu_oe(alu_oe), .alu_la(alu_la),
        .alu_lb(alu_lb), .alu_sh(alu_sh), .alu_r(alu_r), .alu_s(alu_s),
        .alu_v(alu_v), .alu_ne(alu_ne), .alu_ci(alu_ci), .alu_l(alu_l),
        .alu_h(alu_h), .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_carry(alu_carry),
        .res_valid(res_valid), .res_data(res_data), .res_wr(res_wr),
        .res_z(res_z), .res_n(res_n), .res_h(res_h), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural ALU: latches A/B from the bus, combines them per r/ne
    logic [7:0] a_reg, b_reg, bus, bs_mask;
    assign bs_mask = 8'd1 << alu_bs;
    always_comb begin
        if (alu_ne)     alu_result = a_reg & ~b_reg;
        else if (alu_r) alu_result = a_reg | b_reg;
        else            alu_result = a_reg & b_reg;
    end
    assign alu_zero = (alu_result == 8'd0);
    always_comb begin
        case (alu_oe)
            2'd1:    bus = bs_mask;
            2'd2:    bus = alu_op;
            2'd3:    bus = alu_result;
            default: bus = 8'd0;
        endcase
    end
    always @(posedge clk) begin
        if (alu_la) a_reg <= bus;
        if (alu_lb) b_reg <= bus;
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, got, exp);
        end
    endtask

    // reference: instruction semantics, not the ALU micro-sequence
    function automatic logic [7:0] ref_data(input logic [1:0] op, input logic [2:0] b,
                                            input logic [7:0] v);
        logic [7:0] m;
        m = 8'd1 << b;
        case (op)
            2'd1:    return v & ~m;
            2'd2:    return v | m;
            default: return v & m;
        endcase
    endfunction

    function automatic logic ref_z(input logic [1:0] op, input logic [2:0] b,
                                   input logic [7:0] v);
        if (op == 2'd1 || op == 2'd2) return ref_data(op, b, v) == 8'd0;
        return !v[b];
    endfunction

    task automatic check_idle_alu(input string name);
        check({name, "_oe"}, {6'd0, alu_oe}, 8'd0);
        check({name, "_ld"}, {6'd0, alu_la, alu_lb}, 8'd0);
        check({name, "_lh"}, {6'd0, alu_l, alu_h}, 8'd0);
        check({name, "_fn"}, {3'd0, alu_r, alu_s, alu_v, alu_ne, alu_ci}, 8'd0);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [2:0] b, input logic [7:0] v,
                          input bit carry_hi);
        logic is_set, is_res, is_bit;
        is_set = (op == 2'd2);
        is_res = (op == 2'd1);
        is_bit = !(is_set || is_res);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_bit = b; req_val = v;
        check("idle_ready", {7'd0, req_ready}, 8'd1);
        @(negedge clk);
        // post-accept inputs must be ignored
        req_valid = 1'($urandom); req_op = 2'($urandom); req_bit = 3'($urandom);
        req_val = 8'($urandom);
        if (req_valid) begin
            req_valid = 1'b0;
        end
        check("ldb_ready", {7'd0, req_ready}, 8'd0);
        check("ldb_bs", {5'd0, alu_bs}, {5'd0, b});
        check("ldb_oe", {6'd0, alu_oe}, 8'd1);
        check("ldb_ld", {6'd0, alu_la, alu_lb}, 8'd1);
        check("ldb_lh", {6'd0, alu_l, alu_h}, 8'd0);
        @(negedge clk);
        check("lo_ready", {7'd0, req_ready}, 8'd0);
        check("lo_op", alu_op, v);
        check("lo_oe", {6'd0, alu_oe}, 8'd2);
        check("lo_sh", {6'd0, alu_sh}, 8'd0);
        check("lo_ld", {6'd0, alu_la, alu_lb}, 8'd2);
        check("lo_lh", {6'd0, alu_l, alu_h}, 8'd2);
        check("lo_fn", {3'd0, alu_r, alu_s, alu_v, alu_ne, alu_ci},
              {3'd0, is_set, 1'b1, 1'b1, is_res, 1'b0});
        @(negedge clk);
        check("hi_ready", {7'd0, req_ready}, 8'd1);
        check("hi_oe", {6'd0, alu_oe}, 8'd3);
        check("hi_ld", {6'd0, alu_la, alu_lb}, 8'd0);
        check("hi_lh", {6'd0, alu_l, alu_h}, 8'd1);
        check("hi_fn", {3'd0, alu_r, alu_s, alu_v, alu_ne, alu_ci},
              {3'd0, is_set, 1'b1, 1'b1, is_res, 1'b0});
        check("hi_novalid", {7'd0, res_valid}, 8'd0);
        if (carry_hi) begin
            alu_carry = 1'b1;
            err_exp = 1'b1;
        end
        @(negedge clk);
        alu_carry = 1'b0;
        check("res_valid", {7'd0, res_valid}, 8'd1);
        check("res_data", res_data, ref_data(op, b, v));
        check("res_z", {7'd0, res_z}, {7'd0, ref_z(op, b, v)});
        check("res_n", {7'd0, res_n}, 8'd0);
        check("res_h", {7'd0, res_h}, {7'd0, is_bit});
        check("res_wr", {7'd0, res_wr}, {7'd0, !is_bit});
        check("err", {7'd0, err}, {7'd0, err_exp});
        @(negedge clk);
        check("res_pulse", {7'd0, res_valid}, 8'd0);
        check("res_hold", res_data, ref_data(op, b, v));
    endtask

    logic [1:0] bb_op  [3];
    logic [2:0] bb_bit [3];
    logic [7:0] bb_val [3];

    initial begin
        tests = 0; fails = 0; err_exp = 1'b0;
        nreset = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_bit = 3'd0; req_val = 8'd0;
        alu_carry = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", {7'd0, res_valid}, 8'd0);
        check("rst_data", res_data, 8'd0);
        check("rst_flags", {4'd0, res_wr, res_z, res_n, res_h}, 8'd0);
        check("rst_err", {7'd0, err}, 8'd0);
        check_idle_alu("rst");
        nreset = 1'b1;

        // directed cases
        run_op(2'd2, 3'd3, 8'h00, 1'b0);
        run_op(2'd1, 3'd7, 8'hFF, 1'b0);
        run_op(2'd2, 3'd0, 8'hFF, 1'b0);
        run_op(2'd0, 3'd5, 8'hDF, 1'b0);
        run_op(2'd0, 3'd5, 8'h20, 1'b0);
        run_op(2'd3, 3'd1, 8'h02, 1'b0);
        run_op(2'd1, 3'd0, 8'h01, 1'b0);

        // back-to-back with req_valid held high
        bb_op[0] = 2'd2; bb_bit[0] = 3'd6; bb_val[0] = 8'h11;
        bb_op[1] = 2'd1; bb_bit[1] = 3'd4; bb_val[1] = 8'hF0;
        bb_op[2] = 2'd0; bb_bit[2] = 3'd2; bb_val[2] = 8'h04;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c < 9) begin
                req_valid = 1'b1;
                req_op = bb_op[c / 3]; req_bit = bb_bit[c / 3]; req_val = bb_val[c / 3];
            end else begin
                req_valid = 1'b0;
            end
            check("bb_ready", {7'd0, req_ready},
                  {7'd0, (c == 0 || c == 3 || c == 6 || c >= 9)});
            check("bb_valid", {7'd0, res_valid}, {7'd0, (c == 4 || c == 7 || c == 10)});
            if (c == 4 || c == 7 || c == 10) begin
                check("bb_data", res_data,
                      ref_data(bb_op[c / 3 - 1], bb_bit[c / 3 - 1], bb_val[c / 3 - 1]));
            end
        end

        // reset during LO aborts the op
        run_op(2'd1, 3'd7, 8'hFF, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd2; req_bit = 3'd1; req_val = 8'h80;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_lo", {7'd0, alu_l}, 8'd1);
        nreset = 1'b0;
        #1;
        check("arst_valid", {7'd0, res_valid}, 8'd0);
        check("arst_data", res_data, 8'd0);
        check("arst_flags", {4'd0, res_wr, res_z, res_n, res_h}, 8'd0);
        check("arst_ready", {7'd0, req_ready}, 8'd1);
        check_idle_alu("arst");
        @(negedge clk);
        nreset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_novalid", {7'd0, res_valid}, 8'd0);
            check("abort_ready", {7'd0, req_ready}, 8'd1);
        end
        run_op(2'd2, 3'd4, 8'h01, 1'b0);

        // carry during HI sets sticky err
        run_op(2'd0, 3'd3, 8'h08, 1'b1);
        run_op(2'd2, 3'd2, 8'h00, 1'b0);

        // randomized ops against the reference
        for (int i = 0; i < 24; i++) begin
            run_op(2'($urandom), 3'($urandom), 8'($urandom), 1'b0);
        end

        // err clears only on reset
        check("err_sticky", {7'd0, err}, 8'd1);
        @(negedge clk);
        nreset = 1'b0;
        #1;
        err_exp = 1'b0;
        check("err_cleared", {7'd0, err}, 8'd0);
        @(negedge clk);
        nreset = 1'b1;
        run_op(2'd1, 3'd5, 8'h3C, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
